pu_tile_sequencer: RTL and testbench



---
 rtl/pu_pkg.sv | 27 ++
 rtl/pu_tile_sequencer_if.sv | 40 ++++
 rtl/pu_tile_sequencer_finish_tracker.sv | 24 ++
 rtl/pu_tile_sequencer.sv | 153 +++++++++++++++
 tb/tb_pu_tile_sequencer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pu_pkg.sv
// Shared types, defaults and helpers for the PU tile sequencer.
package pu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } pu_seq_state_t;

    localparam int PU_NUM_IC    = 16;
    localparam int PU_NUM_OC    = 16;
    localparam int PU_MAX_TILES = 256;
    localparam int PU_DRAIN_W   = 4;
    localparam int PU_TO_W      = 16;

    // Low n bits set, clipped to w bits; callers size-cast to their mask width.
    function automatic logic [63:0] thermo_mask(input int unsigned n, input int unsigned w);
        logic [63:0] m;
        m = '0;
        for (int unsigned i = 0; i < 64; i++)
            m[i] = (i < n) && (i < w);
        return m;
    endfunction

endpackage

// File: rtl/pu_tile_sequencer_if.sv
// Scheduler-side and index-buffer/APE-side signals of one PU tile sequencer.
interface pu_tile_sequencer_if #(
    parameter int NUM_IC  = 16,
    parameter int NUM_OC  = 16,
    parameter int TILE_W  = 9,
    parameter int DRAIN_W = 4,
    parameter int TO_W    = 16
);
    localparam int IC_W = $clog2(NUM_IC + 1);
    localparam int OC_W = $clog2(NUM_OC + 1);

    logic               start;
    logic               abort;
    logic [IC_W-1:0]    ic_num;
    logic [OC_W-1:0]    oc_num;
    logic [TILE_W-1:0]  tile_num;
    logic [DRAIN_W-1:0] drain_cycles;
    logic [TO_W-1:0]    timeout_limit;
    logic [NUM_IC-1:0]  line_finished;
    logic               done_ack;
    logic [NUM_IC-1:0]  in_line_start;
    logic [NUM_OC-1:0]  ape_enable;
    logic               busy;
    logic [TILE_W-1:0]  tile_idx;
    logic               total_finished;
    logic               error;

    modport master (
        output start, abort, ic_num, oc_num, tile_num, drain_cycles, timeout_limit,
               line_finished, done_ack,
        input  in_line_start, ape_enable, busy, tile_idx, total_finished, error
    );

    modport slave (
        input  start, abort, ic_num, oc_num, tile_num, drain_cycles, timeout_limit,
               line_finished, done_ack,
        output in_line_start, ape_enable, busy, tile_idx, total_finished, error
    );

endinterface

// File: rtl/pu_tile_sequencer_finish_tracker.sv
// Sticky per-line finish accumulator; all_done also counts the current cycle's inputs.
module finish_tracker #(
    parameter int NUM_IC = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [NUM_IC-1:0] line_finished,
    input  logic [NUM_IC-1:0] mask,
    output logic              all_done
);
    logic [NUM_IC-1:0] acc;

    always_ff @(posedge clock) begin
        if (reset || clear)
            acc <= '0;
        else if (enable)
            acc <= acc | (line_finished & mask);
    end

    assign all_done = ((acc | (line_finished & mask)) == mask);

endmodule

// File: rtl/pu_tile_sequencer.sv
// Multi-tile convolution pass sequencer for one PU.
//   state  | meaning
//   IDLE   | waiting for start, config not held
//   LAUNCH | one-cycle in_line_start pulse, tracker/watchdog cleared
//   RUN    | APEs enabled, waiting for every active line to finish
//   DRAIN  | APEs held enabled for drain_cycles after tile completion
//   DONE   | total_finished held until done_ack
module pu_tile_sequencer
    import pu_pkg::*;
#(
    parameter int NUM_IC    = PU_NUM_IC,
    parameter int NUM_OC    = PU_NUM_OC,
    parameter int MAX_TILES = PU_MAX_TILES,
    parameter int DRAIN_W   = PU_DRAIN_W,
    parameter int TO_W      = PU_TO_W
) (
    input  logic               clock,
    input  logic               reset,
    pu_tile_sequencer_if.slave bus
);
    localparam int TILE_W = $clog2(MAX_TILES + 1);

    pu_seq_state_t      state;
    logic [NUM_IC-1:0]  ic_mask_q;
    logic [NUM_OC-1:0]  oc_mask_q;
    logic [TILE_W-1:0]  tile_num_q;
    logic [TILE_W-1:0]  tile_idx_q;
    logic [DRAIN_W-1:0] drain_q;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [TO_W-1:0]    to_q;
    logic [TO_W-1:0]    wd_cnt;
    logic [NUM_IC-1:0]  in_line_start_q;
    logic [NUM_OC-1:0]  ape_enable_q;
    logic               busy_q;
    logic               total_finished_q;
    logic               error_q;
    logic               all_done;
    logic               tile_end;
    logic               more_tiles;

    finish_tracker #(.NUM_IC(NUM_IC)) u_finish (
        .clock         (clock),
        .reset         (reset),
        .clear         (state == ST_LAUNCH),
        .enable        (state == ST_RUN),
        .line_finished (bus.line_finished),
        .mask          (ic_mask_q),
        .all_done      (all_done)
    );

    assign tile_end   = ((state == ST_RUN) && all_done && (drain_q == '0)) ||
                        ((state == ST_DRAIN) && (drain_cnt == DRAIN_W'(1)));
    // One extra bit so tile_num = MAX_TILES compares without wrapping.
    assign more_tiles = (({1'b0, tile_idx_q} + (TILE_W+1)'(1)) < {1'b0, tile_num_q});

    always_ff @(posedge clock) begin
        if (reset || (bus.abort && state != ST_IDLE)) begin
            state            <= ST_IDLE;
            ic_mask_q        <= '0;
            oc_mask_q        <= '0;
            tile_num_q       <= '0;
            tile_idx_q       <= '0;
            drain_q          <= '0;
            drain_cnt        <= '0;
            to_q             <= '0;
            wd_cnt           <= '0;
            in_line_start_q  <= '0;
            ape_enable_q     <= '0;
            busy_q           <= 1'b0;
            total_finished_q <= 1'b0;
            error_q          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        ic_mask_q  <= NUM_IC'(thermo_mask(32'(bus.ic_num), NUM_IC));
                        oc_mask_q  <= NUM_OC'(thermo_mask(32'(bus.oc_num), NUM_OC));
                        tile_num_q <= bus.tile_num;
                        drain_q    <= bus.drain_cycles;
                        to_q       <= bus.timeout_limit;
                        tile_idx_q <= '0;
                        busy_q     <= 1'b1;
                        error_q    <= 1'b0;
                        if (bus.ic_num == '0 || bus.oc_num == '0 || bus.tile_num == '0) begin
                            state            <= ST_DONE;
                            total_finished_q <= 1'b1;
                        end else begin
                            state           <= ST_LAUNCH;
                            in_line_start_q <= NUM_IC'(thermo_mask(32'(bus.ic_num), NUM_IC));
                        end
                    end
                end
                ST_LAUNCH: begin
                    in_line_start_q <= '0;
                    ape_enable_q    <= oc_mask_q;
                    wd_cnt          <= to_q;
                    state           <= ST_RUN;
                end
                ST_RUN: begin
                    if (all_done) begin
                        if (drain_q != '0) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= drain_q;
                        end
                    end else if (to_q != '0 && wd_cnt == TO_W'(1)) begin
                        state            <= ST_DONE;
                        ape_enable_q     <= '0;
                        total_finished_q <= 1'b1;
                        error_q          <= 1'b1;
                    end else if (wd_cnt != '0) begin
                        wd_cnt <= wd_cnt - TO_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt != DRAIN_W'(1))
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                end
                ST_DONE: begin
                    if (bus.done_ack) begin
                        state            <= ST_IDLE;
                        busy_q           <= 1'b0;
                        total_finished_q <= 1'b0;
                        error_q          <= 1'b0;
                        tile_idx_q       <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Post-tile step overrides the RUN/DRAIN next-state choices above.
            if (tile_end) begin
                drain_cnt    <= '0;
                ape_enable_q <= '0;
                if (more_tiles) begin
                    state           <= ST_LAUNCH;
                    tile_idx_q      <= tile_idx_q + TILE_W'(1);
                    in_line_start_q <= ic_mask_q;
                end else begin
                    state            <= ST_DONE;
                    total_finished_q <= 1'b1;
                end
            end
        end
    end

    assign bus.in_line_start  = in_line_start_q;
    assign bus.ape_enable     = ape_enable_q;
    assign bus.busy           = busy_q;
    assign bus.tile_idx       = tile_idx_q;
    assign bus.total_finished = total_finished_q;
    assign bus.error          = error_q;

endmodule

// File: tb/tb_pu_tile_sequencer.sv
// Scoreboarded bench for pu_tile_sequencer: per-pass expectations queued at start, checked at pass end.
module tb_pu_tile_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    pu_tile_sequencer_if #(.NUM_IC(16), .NUM_OC(16), .TILE_W(9), .DRAIN_W(4), .TO_W(16)) bus ();

    pu_tile_sequencer #(
        .NUM_IC(16), .NUM_OC(16), .MAX_TILES(256), .DRAIN_W(4), .TO_W(16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          launches;
        int          ape_cyc;
        logic        err;
        int          last_tile;
        logic [15:0] ic_mask;
        logic [15:0] oc_mask;
        bit          aborted;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle mask checks, pass-end scoreboard pops.
    int   mon_launch = 0;
    int   mon_ape    = 0;
    bit   seen_done  = 0;
    logic done_prev  = 1'b0;
    logic busy_prev  = 1'b0;
    exp_t e;

    always @(negedge clock) begin
        if (bus.in_line_start != '0) begin
            if (sb.size() == 0)
                check_val("launch_unexpected", 32'(bus.in_line_start), 0);
            else begin
                check_val("launch_mask", 32'(bus.in_line_start), 32'(sb[0].ic_mask));
                check_val("launch_tile", 32'(bus.tile_idx), mon_launch);
            end
            mon_launch++;
        end
        if (bus.ape_enable != '0) begin
            if (sb.size() != 0)
                check_val("ape_mask", 32'(bus.ape_enable), 32'(sb[0].oc_mask));
            mon_ape++;
        end
        if (bus.total_finished === 1'b1 && done_prev !== 1'b1) begin
            if (sb.size() == 0)
                check_val("done_unexpected", 1, 0);
            else begin
                e = sb.pop_front();
                check_val("done_not_abort", 0, 32'(e.aborted));
                check_val("pass_error", 32'(bus.error), 32'(e.err));
                check_val("pass_last_tile", 32'(bus.tile_idx), e.last_tile);
                check_val("pass_launches", mon_launch, e.launches);
                check_val("pass_ape_cycles", mon_ape, e.ape_cyc);
            end
            seen_done = 1;
        end
        if (bus.busy === 1'b0 && busy_prev === 1'b1) begin
            if (!seen_done) begin
                if (sb.size() == 0)
                    check_val("idle_unexpected", 1, 0);
                else begin
                    e = sb.pop_front();
                    check_val("pass_aborted", 1, 32'(e.aborted));
                end
            end
            seen_done  = 0;
            mon_launch = 0;
            mon_ape    = 0;
        end
        done_prev = bus.total_finished;
        busy_prev = bus.busy;
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic start_pass(input int ic, input int oc, input int tiles, input int drain,
                              input int to, input int e_launch, input int e_ape,
                              input bit e_err, input int e_tile, input bit e_abort);
        exp_t x;
        x.launches  = e_launch;
        x.ape_cyc   = e_ape;
        x.err       = e_err;
        x.last_tile = e_tile;
        x.ic_mask   = 16'((32'h1 << ic) - 1);
        x.oc_mask   = 16'((32'h1 << oc) - 1);
        x.aborted   = e_abort;
        sb.push_back(x);
        bus.ic_num        = 5'(ic);
        bus.oc_num        = 5'(oc);
        bus.tile_num      = 9'(tiles);
        bus.drain_cycles  = 4'(drain);
        bus.timeout_limit = 16'(to);
        bus.start         = 1'b1;
        tick();
        bus.start         = 1'b0;
    endtask

    // Called at the negedge of the first cycle after start (n=1).
    task automatic wait_done(input string tag, input int exp_n);
        int n;
        n = 1;
        while (bus.total_finished !== 1'b1 && n < exp_n + 20) begin
            tick();
            n++;
        end
        check_val(tag, n, exp_n);
    endtask

    task automatic ack();
        bus.done_ack = 1'b1;
        tick();
        bus.done_ack = 1'b0;
        check_val("ack_busy", 32'(bus.busy), 0);
        check_val("ack_finished", 32'(bus.total_finished), 0);
        check_val("ack_error", 32'(bus.error), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start = 0; bus.abort = 0; bus.ic_num = 0; bus.oc_num = 0; bus.tile_num = 0;
        bus.drain_cycles = 0; bus.timeout_limit = 0; bus.line_finished = 0; bus.done_ack = 0;
        repeat (3) tick();
        reset = 1'b0;
        check_val("rst_busy", 32'(bus.busy), 0);
        check_val("rst_finished", 32'(bus.total_finished), 0);
        check_val("rst_line_start", 32'(bus.in_line_start), 0);
        check_val("rst_ape", 32'(bus.ape_enable), 0);
        check_val("rst_tile_idx", 32'(bus.tile_idx), 0);
        check_val("rst_error", 32'(bus.error), 0);

        // 1: staggered finishes, config changes after start ignored
        start_pass(4, 3, 1, 0, 0, 1, 4, 0, 0, 0);
        check_val("t1_launch", 32'(bus.in_line_start), 32'h000F);
        check_val("t1_launch_ape", 32'(bus.ape_enable), 0);
        check_val("t1_busy", 32'(bus.busy), 1);
        bus.ic_num = 5'd1;
        tick();
        check_val("t1_pulse_once", 32'(bus.in_line_start), 0);
        check_val("t1_run_ape", 32'(bus.ape_enable), 32'h0007);
        for (int b = 0; b < 4; b++) begin
            check_val("t1_not_done", 32'(bus.total_finished), 0);
            bus.line_finished = 16'(32'h1 << b);
            tick();
        end
        bus.line_finished = '0;
        check_val("t1_done", 32'(bus.total_finished), 1);
        check_val("t1_done_ape", 32'(bus.ape_enable), 0);
        repeat (3) tick();
        check_val("t1_done_held", 32'(bus.total_finished), 1);
        ack();

        // 2: three tiles with drain 2, then latency with drain 0
        bus.line_finished = 16'hFFFF;
        start_pass(5, 16, 3, 2, 0, 3, 9, 0, 2, 0);
        wait_done("t2_done_cycle", 13);
        ack();
        start_pass(16, 1, 2, 0, 0, 2, 2, 0, 1, 0);
        wait_done("t2_latency", 5);
        ack();
        start_pass(1, 1, 256, 0, 0, 256, 256, 0, 255, 0);
        wait_done("t2_max_tiles", 513);
        ack();

        // 3: out-of-range lines stuck high
        bus.line_finished = 16'hFFF0;
        start_pass(4, 2, 1, 0, 0, 1, 12, 0, 0, 0);
        repeat (8) tick();
        check_val("t3_stuck_run", 32'(bus.total_finished), 0);
        check_val("t3_stuck_ape", 32'(bus.ape_enable), 32'h0003);
        bus.line_finished = 16'hFFF3;
        tick();
        bus.line_finished = 16'hFFF0;
        repeat (3) tick();
        check_val("t3_partial", 32'(bus.total_finished), 0);
        bus.line_finished = 16'hFFFC;
        tick();
        bus.line_finished = '0;
        check_val("t3_done", 32'(bus.total_finished), 1);
        ack();

        // 4: watchdog expiry, then completion on the limit cycle
        bus.line_finished = 16'h0001;
        start_pass(2, 4, 1, 0, 10, 1, 10, 1, 0, 0);
        wait_done("t4_timeout_cycle", 12);
        check_val("t4_error", 32'(bus.error), 1);
        ack();
        start_pass(2, 4, 1, 0, 10, 1, 10, 0, 0, 0);
        repeat (10) tick();
        check_val("t4_limit_not_done", 32'(bus.total_finished), 0);
        bus.line_finished = 16'h0003;
        tick();
        bus.line_finished = '0;
        check_val("t4_limit_done", 32'(bus.total_finished), 1);
        check_val("t4_limit_error", 32'(bus.error), 0);
        ack();

        // 5: empty passes, and start ignored in DONE
        start_pass(0, 4, 3, 0, 0, 0, 0, 0, 0, 0);
        check_val("t5_ic0_done", 32'(bus.total_finished), 1);
        check_val("t5_ic0_busy", 32'(bus.busy), 1);
        ack();
        start_pass(4, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        check_val("t5_tile0_done", 32'(bus.total_finished), 1);
        bus.ic_num = 5'd4; bus.tile_num = 9'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_val("t5_start_in_done", 32'(bus.total_finished), 1);
        check_val("t5_no_launch", 32'(bus.in_line_start), 0);
        ack();

        // 6: abort mid-DRAIN of tile 1, reset mid-RUN, restarts
        bus.line_finished = 16'hFFFF;
        start_pass(3, 5, 3, 3, 0, 0, 0, 0, 0, 1);
        repeat (7) tick();
        check_val("t6_tile1", 32'(bus.tile_idx), 1);
        check_val("t6_drain_ape", 32'(bus.ape_enable), 32'h001F);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_val("t6_abort_busy", 32'(bus.busy), 0);
        check_val("t6_abort_ape", 32'(bus.ape_enable), 0);
        check_val("t6_abort_tile", 32'(bus.tile_idx), 0);
        check_val("t6_abort_finished", 32'(bus.total_finished), 0);
        start_pass(3, 5, 1, 0, 0, 1, 1, 0, 0, 0);
        wait_done("t6_restart", 3);
        ack();
        bus.line_finished = '0;
        start_pass(4, 2, 2, 0, 0, 0, 0, 0, 0, 1);
        tick();
        check_val("t6_run_ape", 32'(bus.ape_enable), 32'h0003);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("t6_rst_busy", 32'(bus.busy), 0);
        check_val("t6_rst_ape", 32'(bus.ape_enable), 0);
        check_val("t6_rst_finished", 32'(bus.total_finished), 0);
        bus.line_finished = 16'hFFFF;
        start_pass(4, 2, 1, 0, 0, 1, 1, 0, 0, 0);
        wait_done("t6_rst_restart", 3);
        ack();

        tick();
        check_val("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
